// File: rtl/pmu_pkg.sv
// ----------------------------------------------------------------------------
// pmu_pkg
// Shared types and helpers for the PMU register bank arbiter slice.
//   arb_state_t : arbiter state, which also records last cycle's grant
//   idx_w(n)    : index width needed to address n registers
// ----------------------------------------------------------------------------
package pmu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_UPD  = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmu_regbank_arb_if.sv
// ----------------------------------------------------------------------------
// pmu_regbank_arb_if
// Request/ack bundle between the two requesters (AHB slave front end and the
// counter update engine) and the register bank arbiter.
//   bus_req/bus_we/bus_idx/bus_wdata : bus access request (held until bus_ack)
//   bus_ack/bus_rdata                : one-cycle completion pulse + read data
//   upd_req/upd_idx/upd_inc          : counter increment request (held until upd_ack)
//   upd_ack                          : one-cycle update completion pulse
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface pmu_regbank_arb_if
    import pmu_pkg::*;
#(
    parameter int N_REGS    = 20,
    parameter int REG_WIDTH = 32,
    parameter int INC_W     = 8,
    localparam int IDX_W    = idx_w(N_REGS)
);

    logic                 bus_req;
    logic                 bus_we;
    logic [IDX_W-1:0]     bus_idx;
    logic [REG_WIDTH-1:0] bus_wdata;
    logic                 bus_ack;
    logic [REG_WIDTH-1:0] bus_rdata;

    logic                 upd_req;
    logic [IDX_W-1:0]     upd_idx;
    logic [INC_W-1:0]     upd_inc;
    logic                 upd_ack;

    modport master (
        output bus_req, bus_we, bus_idx, bus_wdata,
        output upd_req, upd_idx, upd_inc,
        input  bus_ack, bus_rdata, upd_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_idx, bus_wdata,
        input  upd_req, upd_idx, upd_inc,
        output bus_ack, bus_rdata, upd_ack
    );

endinterface

// File: rtl/pmu_regfile.sv
// ----------------------------------------------------------------------------
// pmu_regfile
// N_REGS x REG_WIDTH register storage, one write port, two combinational
// read ports and a flat view of every register.
//   clk_i, rstn_i         : clock, asynchronous active-low reset (clears all)
//   we_i/widx_i/wdata_i   : write port; out-of-range index is ignored
//   raddr_a_i/rdata_a_o   : read port A; out-of-range index reads 0
//   raddr_b_i/rdata_b_o   : read port B; out-of-range index reads 0
//   regs_o                : all registers, reg[i] at bits [i*REG_WIDTH +: REG_WIDTH]
// ----------------------------------------------------------------------------
module pmu_regfile
    import pmu_pkg::*;
#(
    parameter int N_REGS    = 20,
    parameter int REG_WIDTH = 32,
    localparam int IDX_W    = idx_w(N_REGS)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        we_i,
    input  logic [IDX_W-1:0]            widx_i,
    input  logic [REG_WIDTH-1:0]        wdata_i,
    input  logic [IDX_W-1:0]            raddr_a_i,
    output logic [REG_WIDTH-1:0]        rdata_a_o,
    input  logic [IDX_W-1:0]            raddr_b_i,
    output logic [REG_WIDTH-1:0]        rdata_b_o,
    output logic [N_REGS*REG_WIDTH-1:0] regs_o
);

    logic [REG_WIDTH-1:0] regs_q [N_REGS];
    logic [REG_WIDTH-1:0] regs_d [N_REGS];

    // Decoding by comparison against every legal index means an
    // out-of-range address simply matches nothing: writes vanish and
    // reads fall through to zero without any explicit range check.
    always_comb begin
        regs_d    = regs_q;
        rdata_a_o = '0;
        rdata_b_o = '0;
        regs_o    = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (we_i && (widx_i == IDX_W'(i))) begin
                regs_d[i] = wdata_i;
            end
            if (raddr_a_i == IDX_W'(i)) begin
                rdata_a_o = regs_q[i];
            end
            if (raddr_b_i == IDX_W'(i)) begin
                rdata_b_o = regs_q[i];
            end
            regs_o[i*REG_WIDTH +: REG_WIDTH] = regs_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/pmu_regbank_arb.sv
// ----------------------------------------------------------------------------
// pmu_regbank_arb
// Arbitrates the single write port of the PMU register bank between the AHB
// slave front end (register reads/writes, priority) and the counter update
// engine (read-add-write of one counter). A starvation counter forces an
// update grant after MAX_WAIT denied cycles.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   bus_if        : slave side of the request/ack bundle (bus + update)
//   ovf_o         : one-cycle pulse with upd ack when an update wrapped
//   ovf_idx_o     : counter index that wrapped, valid with ovf_o
//   regs_o        : flat view of all registers
// Each access completes at its grant edge; the ack follows one cycle later.
// ----------------------------------------------------------------------------
module pmu_regbank_arb
    import pmu_pkg::*;
#(
    parameter int N_REGS    = 20,
    parameter int REG_WIDTH = 32,
    parameter int INC_W     = 8,
    parameter int MAX_WAIT  = 4,
    localparam int IDX_W    = idx_w(N_REGS)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    pmu_regbank_arb_if.slave            bus_if,
    output logic                        ovf_o,
    output logic [IDX_W-1:0]            ovf_idx_o,
    output logic [N_REGS*REG_WIDTH-1:0] regs_o
);

    localparam int                CNT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [IDX_W:0]    IDX_LIMIT = (IDX_W + 1)'(N_REGS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    arb_state_t           state_q,      state_d;
    logic [CNT_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic [REG_WIDTH-1:0] bus_rdata_q,  bus_rdata_d;
    logic                 ovf_q,        ovf_d;
    logic [IDX_W-1:0]     ovf_idx_q,    ovf_idx_d;

    logic                 bus_ack, upd_ack;
    logic                 bus_elig, upd_elig;
    logic                 bus_idx_ok, upd_idx_ok;
    arb_state_t           grant;
    logic [REG_WIDTH-1:0] bus_rd, upd_rd;
    logic [REG_WIDTH:0]   upd_sum;
    logic                 rf_we;
    logic [IDX_W-1:0]     rf_widx;
    logic [REG_WIDTH-1:0] rf_wdata;

    pmu_regfile #(
        .N_REGS    (N_REGS),
        .REG_WIDTH (REG_WIDTH)
    ) u_regfile (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .we_i      (rf_we),
        .widx_i    (rf_widx),
        .wdata_i   (rf_wdata),
        .raddr_a_i (bus_if.bus_idx),
        .rdata_a_o (bus_rd),
        .raddr_b_i (bus_if.upd_idx),
        .rdata_b_o (upd_rd),
        .regs_o    (regs_o)
    );

    always_comb begin
        // The state register doubles as the ack source; a requester whose
        // ack is high still holds req, so it is masked for that cycle.
        bus_ack    = (state_q == ARB_BUS);
        upd_ack    = (state_q == ARB_UPD);
        bus_elig   = bus_if.bus_req && !bus_ack;
        upd_elig   = bus_if.upd_req && !upd_ack;
        bus_idx_ok = ({1'b0, bus_if.bus_idx} < IDX_LIMIT);
        upd_idx_ok = ({1'b0, bus_if.upd_idx} < IDX_LIMIT);

        grant = ARB_IDLE;
        if (upd_elig && (starve_cnt_q == CNT_MAX)) begin
            grant = ARB_UPD;
        end else if (bus_elig) begin
            grant = ARB_BUS;
        end else if (upd_elig) begin
            grant = ARB_UPD;
        end
        state_d = grant;

        starve_cnt_d = starve_cnt_q;
        if (!bus_if.upd_req || (grant == ARB_UPD)) begin
            starve_cnt_d = '0;
        end else if (!upd_ack) begin
            starve_cnt_d = sat_inc(starve_cnt_q);
        end

        // One extra bit on the adder captures the wrap past 2^REG_WIDTH-1.
        upd_sum = (REG_WIDTH + 1)'(upd_rd) + (REG_WIDTH + 1)'(bus_if.upd_inc);

        rf_we    = 1'b0;
        rf_widx  = bus_if.bus_idx;
        rf_wdata = bus_if.bus_wdata;
        if (grant == ARB_UPD) begin
            rf_we    = upd_idx_ok;
            rf_widx  = bus_if.upd_idx;
            rf_wdata = upd_sum[REG_WIDTH-1:0];
        end else if (grant == ARB_BUS) begin
            rf_we    = bus_if.bus_we && bus_idx_ok;
        end

        // Read data is the pre-write value and is held until the next read.
        bus_rdata_d = bus_rdata_q;
        if ((grant == ARB_BUS) && !bus_if.bus_we) begin
            bus_rdata_d = bus_rd;
        end

        ovf_d     = (grant == ARB_UPD) && upd_idx_ok && upd_sum[REG_WIDTH];
        ovf_idx_d = ovf_d ? bus_if.upd_idx : ovf_idx_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            bus_rdata_q  <= '0;
            ovf_q        <= 1'b0;
            ovf_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            bus_rdata_q  <= bus_rdata_d;
            ovf_q        <= ovf_d;
            ovf_idx_q    <= ovf_idx_d;
        end
    end

    assign bus_if.bus_ack   = bus_ack;
    assign bus_if.upd_ack   = upd_ack;
    assign bus_if.bus_rdata = bus_rdata_q;
    assign ovf_o            = ovf_q;
    assign ovf_idx_o        = ovf_idx_q;

endmodule

// File: tb/tb_pmu_regbank_arb.sv
// ----------------------------------------------------------------------------
// tb_pmu_regbank_arb
// Directed bench for pmu_regbank_arb: a table of single transactions with
// hand-computed results, then hand-written multi-cycle sequences for
// contention, same-index ordering and reset in the middle of an access.
// ----------------------------------------------------------------------------
module tb_pmu_regbank_arb;

    localparam int N_REGS    = 20;
    localparam int REG_WIDTH = 32;
    localparam int INC_W     = 8;
    localparam int MAX_WAIT  = 4;
    localparam int IDX_W     = 5;
    localparam int N_VECS    = 15;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        ovf;
    logic [IDX_W-1:0]            ovf_idx;
    logic [N_REGS*REG_WIDTH-1:0] regs;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pmu_regbank_arb_if #(
        .N_REGS    (N_REGS),
        .REG_WIDTH (REG_WIDTH),
        .INC_W     (INC_W)
    ) bif ();

    pmu_regbank_arb #(
        .N_REGS    (N_REGS),
        .REG_WIDTH (REG_WIDTH),
        .INC_W     (INC_W),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .bus_if    (bif),
        .ovf_o     (ovf),
        .ovf_idx_o (ovf_idx),
        .regs_o    (regs)
    );

    typedef struct {
        bit          is_upd;
        bit          we;
        logic [4:0]  idx;
        logic [31:0] data;       // write data or increment
        logic [31:0] exp_rdata;  // bus_rdata in the ack cycle (bus ops)
        int          chk_idx;
        logic [31:0] exp_reg;
        bit          exp_ovf;
        logic [4:0]  exp_ovf_idx;
    } vec_t;

    vec_t vecs [N_VECS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] reg_at(input int idx);
        return regs[idx*REG_WIDTH +: REG_WIDTH];
    endfunction

    function automatic logic [31:0] acks();
        return {30'd0, bif.bus_ack, bif.upd_ack};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // is_upd we idx data exp_rdata chk_idx exp_reg exp_ovf exp_ovf_idx
        vecs[0]  = '{0, 1, 5'd3,  32'hDEADBEEF, 32'h00000000, 3,  32'hDEADBEEF, 0, 5'd0};
        vecs[1]  = '{0, 0, 5'd3,  32'h00000000, 32'hDEADBEEF, 3,  32'hDEADBEEF, 0, 5'd0};
        vecs[2]  = '{0, 1, 5'd5,  32'hFFFFFFF0, 32'hDEADBEEF, 5,  32'hFFFFFFF0, 0, 5'd0};
        vecs[3]  = '{1, 0, 5'd5,  32'h00000020, 32'h00000000, 5,  32'h00000010, 1, 5'd5};
        vecs[4]  = '{1, 0, 5'd5,  32'h00000001, 32'h00000000, 5,  32'h00000011, 0, 5'd0};
        vecs[5]  = '{0, 0, 5'd25, 32'h00000000, 32'h00000000, 5,  32'h00000011, 0, 5'd0};
        vecs[6]  = '{1, 0, 5'd25, 32'h000000FF, 32'h00000000, 5,  32'h00000011, 0, 5'd0};
        vecs[7]  = '{0, 1, 5'd25, 32'h12345678, 32'h00000000, 19, 32'h00000000, 0, 5'd0};
        vecs[8]  = '{0, 1, 5'd19, 32'hA5A5A5A5, 32'h00000000, 19, 32'hA5A5A5A5, 0, 5'd0};
        vecs[9]  = '{0, 0, 5'd19, 32'h00000000, 32'hA5A5A5A5, 19, 32'hA5A5A5A5, 0, 5'd0};
        vecs[10] = '{1, 0, 5'd0,  32'h000000FF, 32'h00000000, 0,  32'h000000FF, 0, 5'd0};
        vecs[11] = '{0, 1, 5'd4,  32'hFFFFFFFF, 32'hA5A5A5A5, 4,  32'hFFFFFFFF, 0, 5'd0};
        vecs[12] = '{1, 0, 5'd4,  32'h00000001, 32'h00000000, 4,  32'h00000000, 1, 5'd4};
        vecs[13] = '{1, 0, 5'd19, 32'h000000FF, 32'h00000000, 19, 32'hA5A5A6A4, 0, 5'd0};
        vecs[14] = '{0, 0, 5'd5,  32'h00000000, 32'h00000011, 5,  32'h00000011, 0, 5'd0};

        rstn          = 1'b0;
        bif.bus_req   = 1'b0;
        bif.bus_we    = 1'b0;
        bif.bus_idx   = '0;
        bif.bus_wdata = '0;
        bif.upd_req   = 1'b0;
        bif.upd_idx   = '0;
        bif.upd_inc   = '0;

        #12;
        check("reset_acks",  acks(), 32'd0);
        check("reset_rdata", bif.bus_rdata, 32'd0);
        check("reset_ovf",   {26'd0, ovf_idx, ovf}, 32'd0);
        check("reset_regs",  32'(|regs), 32'd0);
        rstn = 1'b1;
        step();

        // ---- table of single transactions ----
        for (int i = 0; i < N_VECS; i++) begin
            if (vecs[i].is_upd) begin
                bif.upd_req = 1'b1;
                bif.upd_idx = vecs[i].idx;
                bif.upd_inc = vecs[i].data[INC_W-1:0];
            end else begin
                bif.bus_req   = 1'b1;
                bif.bus_we    = vecs[i].we;
                bif.bus_idx   = vecs[i].idx;
                bif.bus_wdata = vecs[i].data;
            end
            step();
            if (vecs[i].is_upd) begin
                check($sformatf("v%0d_upd_ack", i), acks(), 32'd1);
                check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
                if (vecs[i].exp_ovf)
                    check($sformatf("v%0d_ovf_idx", i), 32'(ovf_idx), 32'(vecs[i].exp_ovf_idx));
            end else begin
                check($sformatf("v%0d_bus_ack", i), acks(), 32'd2);
                check($sformatf("v%0d_rdata", i), bif.bus_rdata, vecs[i].exp_rdata);
                check($sformatf("v%0d_ovf", i), 32'(ovf), 32'd0);
            end
            check($sformatf("v%0d_reg%0d", i, vecs[i].chk_idx), reg_at(vecs[i].chk_idx), vecs[i].exp_reg);
            bif.bus_req = 1'b0;
            bif.upd_req = 1'b0;
            step();
            check($sformatf("v%0d_ack_drop", i), acks(), 32'd0);
        end

        // ---- both requesters held continuously: acks alternate ----
        bif.bus_req   = 1'b1;
        bif.bus_we    = 1'b1;
        bif.bus_idx   = 5'd10;
        bif.bus_wdata = 32'h0BADF00D;
        bif.upd_req   = 1'b1;
        bif.upd_idx   = 5'd11;
        bif.upd_inc   = 8'd1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("contend_c%0d_acks", k), acks(), (k % 2 == 0) ? 32'd2 : 32'd1);
        end
        bif.bus_req = 1'b0;
        bif.upd_req = 1'b0;
        check("contend_reg11", reg_at(11), 32'd4);
        check("contend_reg10", reg_at(10), 32'h0BADF00D);
        step();
        check("contend_idle", acks(), 32'd0);

        // ---- same index from both: bus first, then update ----
        bif.bus_req   = 1'b1;
        bif.bus_we    = 1'b1;
        bif.bus_idx   = 5'd2;
        bif.bus_wdata = 32'd7;
        bif.upd_req   = 1'b1;
        bif.upd_idx   = 5'd2;
        bif.upd_inc   = 8'd1;
        step();
        check("same_idx_bus_ack", acks(), 32'd2);
        check("same_idx_reg2_a", reg_at(2), 32'd7);
        bif.bus_req = 1'b0;
        step();
        check("same_idx_upd_ack", acks(), 32'd1);
        check("same_idx_reg2_b", reg_at(2), 32'd8);
        bif.upd_req = 1'b0;
        step();
        check("same_idx_idle", acks(), 32'd0);

        // ---- reset while a bus request is active ----
        bif.bus_req   = 1'b1;
        bif.bus_we    = 1'b1;
        bif.bus_idx   = 5'd6;
        bif.bus_wdata = 32'h00000055;
        step();
        check("rst_pre_ack", acks(), 32'd2);
        check("rst_pre_reg6", reg_at(6), 32'h00000055);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_acks", acks(), 32'd0);
        check("rst_regs", 32'(|regs), 32'd0);
        check("rst_rdata", bif.bus_rdata, 32'd0);
        step();
        check("rst_hold_acks", acks(), 32'd0);
        #3;
        rstn = 1'b1;
        step();
        check("rst_reissue_ack", acks(), 32'd2);
        check("rst_reissue_reg6", reg_at(6), 32'h00000055);
        bif.bus_req = 1'b0;
        step();
        check("rst_reissue_idle", acks(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
